afe_reader: RTL and testbench
=============================

AFE_READER -- requirements
Module: afe_reader

Interface
REQ-001 SHALL: clock and reset are one clock; reset is asynchronous and active-low.
REQ-002 SHALL: div_clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL: ini_over  input  1  register initialisation complete; gates all reads.
REQ-005 SHALL: adc_rdy  input  1  AFE ADC_RDY pin; asynchronous to div_clk.
REQ-006 SHALL: spi_done  input  1  one-cycle pulse from the SPI byte engine at the end of each byte.
REQ-007 SHALL: rx_data  input  8  byte received from the engine; valid in the spi_done cycle.
REQ-008 SHALL: overrun_clr  input  1  clears the overrun flag.
REQ-009 SHALL: rd_wr_en  output  1  byte-transfer request to the engine.
REQ-010 SHALL: rd_rd_en  output  1  high while the current byte is a data (readback) byte.
REQ-011 SHALL: rd_tx_data  output  8  byte to shift out.
REQ-012 SHALL: data_part  output  2  byte index: 0 = address, 1 = high, 2 = mid, 3 = low.
REQ-013 SHALL: led2_val, aled2_val, led1_val, aled1_val  output  24 each  last complete sample set.
REQ-014 SHALL: led2_aled2_val, led1_aled1_val  output  24 each  AFE difference values (see Configuration).
REQ-015 SHALL: data_valid  output  1  one-cycle pulse when a new sample set is on the outputs.
REQ-016 SHALL: busy  output  1  high whenever the state is not IDLE.
REQ-017 SHALL: overrun  output  1  sticky flag: adc_rdy arrived while busy.

Function
REQ-018 SHALL: synchronise adc_rdy with two flops, then detect the rising edge with a third flop; trigger-to-ADDR latency is 3 cycles.
REQ-019 SHALL: use these states:
- IDLE
- ADDR
- DATA_H
- DATA_M
- DATA_L
- DONE
REQ-020 SHALL: IDLE -> ADDR on a detected edge when ini_over = 1; edges are ignored when ini_over = 0.
REQ-021 SHALL: set data_part in the byte states as follows: ADDR = 0, DATA_H = 1, DATA_M = 2, DATA_L = 3; data_part = 0 in IDLE and DONE.
REQ-022 SHALL: drive rd_tx_data with the register address in ADDR (sequence 0x2A, 0x2B, 0x2C, 0x2D) and with 0x00 in the data states.
REQ-023 SHALL: assert rd_wr_en in the byte states; rd_wr_en is low in the cycle after each spi_done and in IDLE and DONE.
REQ-024 SHALL: assert rd_rd_en only in DATA_H, DATA_M and DATA_L.
REQ-025 SHALL: on spi_done in a data state, shift rx_data MSB-first into a 24-bit shadow register; the byte in DATA_L completes the word.
REQ-026 SHALL: on spi_done in DATA_L, store the shadow word into the slot for the current register index.
REQ-027 SHALL: after the DATA_L store, go to ADDR with the index incremented, or go to DONE if the index was the last one.
REQ-028 SHALL: in DONE, copy all slots to the outputs at once, pulse data_valid for 1 cycle, clear the index and return to IDLE.
REQ-029 SHALL: leave the outputs unchanged at all other times; a partial set is never exposed.
REQ-030 SHALL: set overrun on an adc_rdy edge while busy; that edge is otherwise discarded.
REQ-031 SHALL: clear overrun with overrun_clr; if set and clear coincide, set wins.
REQ-032 SHALL: finish the current set if ini_over falls mid-set; no new set starts while ini_over = 0.
REQ-033 SHALL: ignore spi_done while in IDLE or DONE.

Reset
REQ-034 SHALL: rst_n low asynchronously forces the state to IDLE, the index to 0 and the synchroniser flops to 0.
REQ-035 SHALL: rst_n low clears the shadow register and all slots to 0.
REQ-036 SHALL: rst_n low forces every output to 0; the output state on release is all zero with busy = 0.
REQ-037 SHALL: reset asserted mid-transfer abandons the set; no data_valid pulse is produced.

Configuration
REQ-038 SHALL: use the macro AFE_DIFF_READ_EN to add or remove the difference reads.
REQ-039 SHALL: when AFE_DIFF_READ_EN is defined, the sequence extends to 0x2E and 0x2F, loading led2_aled2_val and led1_aled1_val, for six registers per set.
REQ-040 SHALL: when AFE_DIFF_READ_EN is undefined, only four registers are read per set and led2_aled2_val and led1_aled1_val are tied to 0.

Verification
REQ-041 SHALL: ini_over = 1, one adc_rdy pulse, responder returns 0x12,0x34,0x56 for 0x2A and 0x00,0x00,0x01 for the rest -> led2_val = 0x123456, aled2_val = 0x000001, one data_valid pulse, exactly 16 spi_done handshakes (24 with the macro).
REQ-042 SHALL: ini_over = 0, adc_rdy pulses -> rd_wr_en stays 0, busy stays 0.
REQ-043 SHALL: second adc_rdy edge during DATA_M of the 0x2B read -> overrun = 1, set completes normally, no extra set starts; overrun_clr -> overrun = 0.
REQ-044 SHALL: rst_n low during DATA_H of 0x2C -> all outputs 0 at once, no data_valid pulse; next edge restarts at 0x2A.
REQ-045 SHALL: with AFE_DIFF_READ_EN, 0x2E returns 0xFFFFFE -> led2_aled2_val = 0xFFFFFE; without the macro that port stays 0.
REQ-046 SHALL: spi_done asserted for 1 cycle at 5-cycle spacing -> rd_wr_en is low exactly one cycle after each spi_done, and data_part steps 0,1,2,3 per register.

Source files
------------

// File: rtl/afe_reader.sv
// ---------------------------------------------------------------------------
// afe_reader
//   Reads the AFE sample registers over a byte-oriented SPI engine each time
//   the AFE signals ADC_RDY. Each register is read as one address byte
//   followed by three data bytes (high, mid, low). The words are collected
//   into internal slots and published together as one sample set.
//
//   Optional feature: define AFE_DIFF_READ_EN to extend each set with the
//   difference registers 0x2E/0x2F (six registers instead of four).
//
// Ports
//   div_clk         system clock, rising edge
//   rst_n           asynchronous active-low reset
//   ini_over        register initialisation complete; gates new sets
//   adc_rdy         AFE ADC_RDY pin (asynchronous)
//   spi_done        one-cycle end-of-byte pulse from the SPI engine
//   rx_data         received byte, valid with spi_done
//   overrun_clr     clears the sticky overrun flag
//   rd_wr_en        byte-transfer request to the engine
//   rd_rd_en        current byte is a readback (data) byte
//   rd_tx_data      byte to shift out (address or 0x00)
//   data_part       byte index: 0 addr, 1 high, 2 mid, 3 low
//   led2_val .. aled1_val, led2_aled2_val, led1_aled1_val
//                   last complete sample set
//   data_valid      one-cycle pulse when a new set is on the outputs
//   busy            state is not IDLE
//   overrun         sticky: adc_rdy edge arrived while busy
//   state_dbg       current FSM state encoding (debug)
//
// Handshake: rd_wr_en high requests a byte; the engine answers with a
// single-cycle spi_done. rd_wr_en drops for exactly the cycle after each
// spi_done so the engine sees a fresh request for the next byte.
// ---------------------------------------------------------------------------
module afe_reader (
   input  logic        div_clk,
   input  logic        rst_n,
   input  logic        ini_over,
   input  logic        adc_rdy,
   input  logic        spi_done,
   input  logic [7:0]  rx_data,
   input  logic        overrun_clr,
   output logic        rd_wr_en,
   output logic        rd_rd_en,
   output logic [7:0]  rd_tx_data,
   output logic [1:0]  data_part,
   output logic [23:0] led2_val,
   output logic [23:0] aled2_val,
   output logic [23:0] led1_val,
   output logic [23:0] aled1_val,
   output logic [23:0] led2_aled2_val,
   output logic [23:0] led1_aled1_val,
   output logic        data_valid,
   output logic        busy,
   output logic        overrun,
   output logic [2:0]  state_dbg
);

`ifdef AFE_DIFF_READ_EN
   localparam int NUM_REGS = 6;
`else
   localparam int NUM_REGS = 4;
`endif
   localparam int         IDX_W     = $clog2(NUM_REGS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
   localparam logic [7:0] BASE_ADDR = 8'h2A;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      DATA_H = 3'd2,
      DATA_M = 3'd3,
      DATA_L = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  idx;
   logic              sync1, sync2, sync3;
   logic              rdy_edge;
   logic              wr_hold;
   logic              byte_state;
   logic [23:0]       shadow;
   logic [23:0]       slot [0:NUM_REGS-1];

   // Two-flop synchroniser, third flop for rising-edge detection.
   always_ff @(posedge div_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= adc_rdy;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rdy_edge = sync2 & ~sync3;

   // FSM state register
   always_ff @(posedge div_clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state and decoded outputs
   always_comb begin
      state_nxt  = state;
      byte_state = 1'b0;
      rd_rd_en   = 1'b0;
      rd_tx_data = 8'h00;
      data_part  = 2'd0;
      busy       = (state != IDLE);
      state_dbg  = state;
      case (state)
         IDLE: begin
            if (rdy_edge && ini_over) state_nxt = ADDR;
         end
         ADDR: begin
            byte_state = 1'b1;
            rd_tx_data = BASE_ADDR + 8'(idx);
            data_part  = 2'd0;
            if (spi_done) state_nxt = DATA_H;
         end
         DATA_H: begin
            byte_state = 1'b1;
            rd_rd_en   = 1'b1;
            data_part  = 2'd1;
            if (spi_done) state_nxt = DATA_M;
         end
         DATA_M: begin
            byte_state = 1'b1;
            rd_rd_en   = 1'b1;
            data_part  = 2'd2;
            if (spi_done) state_nxt = DATA_L;
         end
         DATA_L: begin
            byte_state = 1'b1;
            rd_rd_en   = 1'b1;
            data_part  = 2'd3;
            if (spi_done) state_nxt = (idx == LAST_IDX) ? DONE : ADDR;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      rd_wr_en = byte_state & ~wr_hold;
   end

   // Datapath: shadow shifting, slot capture, publication and overrun.
   always_ff @(posedge div_clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         wr_hold    <= 1'b0;
         shadow     <= 24'h0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
         led2_val   <= 24'h0;
         aled2_val  <= 24'h0;
         led1_val   <= 24'h0;
         aled1_val  <= 24'h0;
         for (int i = 0; i < NUM_REGS; i++) slot[i] <= 24'h0;
      end else begin
         wr_hold    <= byte_state & spi_done;
         data_valid <= 1'b0;

         if (spi_done && rd_rd_en) shadow <= {shadow[15:0], rx_data};

         // The low byte completes the word, so capture it straight from rx_data.
         if (spi_done && state == DATA_L) begin
            slot[idx] <= {shadow[15:0], rx_data};
            if (idx != LAST_IDX) idx <= idx + 1'b1;
         end

         if (state == DONE) begin
            led2_val   <= slot[0];
            aled2_val  <= slot[1];
            led1_val   <= slot[2];
            aled1_val  <= slot[3];
            data_valid <= 1'b1;
            idx        <= '0;
         end

         // Set has priority over clear so no overrun event is lost.
         if (rdy_edge && busy) overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

`ifdef AFE_DIFF_READ_EN
   always_ff @(posedge div_clk or negedge rst_n) begin
      if (!rst_n) begin
         led2_aled2_val <= 24'h0;
         led1_aled1_val <= 24'h0;
      end else if (state == DONE) begin
         led2_aled2_val <= slot[4];
         led1_aled1_val <= slot[5];
      end
   end
`else
   assign led2_aled2_val = 24'h0;
   assign led1_aled1_val = 24'h0;
`endif

endmodule

// File: tb/tb_afe_reader.sv
// ---------------------------------------------------------------------------
// tb_afe_reader
//   Directed bench for afe_reader. A responder process models the SPI byte
//   engine and checks every byte request; a monitor pops expected sample sets
//   from a queue whenever data_valid is seen.
// ---------------------------------------------------------------------------
module tb_afe_reader;

   logic        div_clk;
   logic        rst_n;
   logic        ini_over;
   logic        adc_rdy;
   logic        spi_done;
   logic [7:0]  rx_data;
   logic        overrun_clr;
   logic        rd_wr_en;
   logic        rd_rd_en;
   logic [7:0]  rd_tx_data;
   logic [1:0]  data_part;
   logic [23:0] led2_val, aled2_val, led1_val, aled1_val;
   logic [23:0] led2_aled2_val, led1_aled1_val;
   logic        data_valid;
   logic        busy;
   logic        overrun;
   logic [2:0]  state_dbg;

`ifdef AFE_DIFF_READ_EN
   localparam int SPI_PER_SET = 24;
   localparam logic [47:0] DIFF0 = {24'hFFFFFE, 24'h000001};
   localparam logic [47:0] DIFF1 = {24'h2EC3D1, 24'h2FC3D0};
`else
   localparam int SPI_PER_SET = 16;
   localparam logic [47:0] DIFF0 = 48'h0;
   localparam logic [47:0] DIFF1 = 48'h0;
`endif
   // Hand-computed expected sets: {led2, aled2, led1, aled1, led2-aled2, led1-aled1}
   localparam logic [143:0] EXP0 = {24'h123456, 24'h000001, 24'h000001, 24'h000001, DIFF0};
   localparam logic [143:0] EXP1 = {24'h2AC3D5, 24'h2BC3D4, 24'h2CC3D3, 24'h2DC3D2, DIFF1};

   logic [143:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int n_valid  = 0;
   int n_spi    = 0;
   int resp_var = 0;
   int cur_reg  = -1;
   logic [7:0] first_tx = 8'h00;

   afe_reader dut (
      .div_clk        (div_clk),
      .rst_n          (rst_n),
      .ini_over       (ini_over),
      .adc_rdy        (adc_rdy),
      .spi_done       (spi_done),
      .rx_data        (rx_data),
      .overrun_clr    (overrun_clr),
      .rd_wr_en       (rd_wr_en),
      .rd_rd_en       (rd_rd_en),
      .rd_tx_data     (rd_tx_data),
      .data_part      (data_part),
      .led2_val       (led2_val),
      .aled2_val      (aled2_val),
      .led1_val       (led1_val),
      .aled1_val      (aled1_val),
      .led2_aled2_val (led2_aled2_val),
      .led1_aled1_val (led1_aled1_val),
      .data_valid     (data_valid),
      .busy           (busy),
      .overrun        (overrun),
      .state_dbg      (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      div_clk = 1'b0;
      forever #5 div_clk = ~div_clk;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] resp_word(input int v, input logic [7:0] addr);
      if (v == 1) return {addr, 8'hC3, ~addr};
      if (addr == 8'h2A) return 24'h123456;
      if (addr == 8'h2E) return 24'hFFFFFE;
      return 24'h000001;
   endfunction

   task automatic pulse_adc();
      @(negedge div_clk);
      adc_rdy = 1'b1;
      repeat (3) @(negedge div_clk);
      adc_rdy = 1'b0;
   endtask

   task automatic wait_valid(input int target, input string name);
      int n = 0;
      while (n_valid < target && n < 2000) begin
         @(negedge div_clk);
         n++;
      end
      check(name, 64'(n_valid), 64'(target));
   endtask

   task automatic wait_state(input logic [2:0] st, input int reg_i, input string name);
      int n = 0;
      while (!(state_dbg == st && cur_reg == reg_i) && n < 1000) begin
         @(negedge div_clk);
         n++;
      end
      check(name, 64'(n < 1000), 64'd1);
   endtask

   // ---------------- SPI engine responder ----------------
   initial begin : responder
      int byte_cnt;
      logic [1:0] s_part;
      logic [7:0] s_tx;
      logic       s_rd;
      logic [7:0] exp_addr;
      logic [23:0] w;
      byte_cnt = 0;
      spi_done = 1'b0;
      rx_data  = 8'h00;
      forever begin
         @(negedge div_clk);
         if (!rst_n || data_valid) byte_cnt = 0;
         else if (rd_wr_en) begin
            s_part   = data_part;
            s_tx     = rd_tx_data;
            s_rd     = rd_rd_en;
            cur_reg  = byte_cnt / 4;
            exp_addr = 8'h2A + 8'(byte_cnt / 4);
            if (byte_cnt == 0) first_tx = s_tx;
            check("data_part", 64'(s_part), 64'(byte_cnt % 4));
            check("rd_rd_en", 64'(s_rd), 64'((byte_cnt % 4) != 0));
            check("rd_tx_data", 64'(s_tx), (byte_cnt % 4 == 0) ? 64'(exp_addr) : 64'h0);
            w = resp_word(resp_var, exp_addr);
            case (byte_cnt % 4)
               1:       rx_data = w[23:16];
               2:       rx_data = w[15:8];
               3:       rx_data = w[7:0];
               default: rx_data = 8'h00;
            endcase
            repeat (3) @(negedge div_clk);
            spi_done = 1'b1;
            if (rst_n) n_spi++;
            @(negedge div_clk);
            spi_done = 1'b0;
            rx_data  = 8'h00;
            if (rst_n) begin
               check("wr_en_gap", 64'(rd_wr_en), 64'd0);
               byte_cnt++;
            end
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin : monitor
      logic [143:0] act, exp;
      logic prev_dv;
      prev_dv = 1'b0;
      forever begin
         @(negedge div_clk);
         if (data_valid) begin
            n_valid++;
            n_checks++;
            act = {led2_val, aled2_val, led1_val, aled1_val, led2_aled2_val, led1_aled1_val};
            if (prev_dv) begin
               n_errors++;
               $display("FAIL dv_width: data_valid high %0d cycles, required 1", 2);
            end else if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_set: got %0h with empty queue", act);
            end else begin
               exp = exp_q.pop_front();
               if (act !== exp) begin
                  n_errors++;
                  $display("FAIL sample_set: got %0h expected %0h", act, exp);
               end
            end
         end
         prev_dv = data_valid;
      end
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int spi0, dv0, n;
      logic seen;
      rst_n       = 1'b0;
      ini_over    = 1'b0;
      adc_rdy     = 1'b0;
      overrun_clr = 1'b0;
      repeat (3) @(negedge div_clk);
      check("rst_ctrl", {rd_wr_en, rd_rd_en, rd_tx_data, data_part, data_valid, busy, overrun}, 64'h0);
      check("rst_led2_aled2", {led2_val, aled2_val}, 64'h0);
      check("rst_led1_aled1", {led1_val, aled1_val}, 64'h0);
      check("rst_diff", {led2_aled2_val, led1_aled1_val}, 64'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge div_clk);

      // Basic set
      ini_over = 1'b1;
      resp_var = 0;
      spi0 = n_spi;
      exp_q.push_back(EXP0);
      pulse_adc();
      wait_valid(1, "set1_valid");
      repeat (5) @(negedge div_clk);
      check("set1_spi_count", 64'(n_spi - spi0), 64'(SPI_PER_SET));
      check("set1_led2", 64'(led2_val), 64'h123456);
      check("set1_aled2", 64'(aled2_val), 64'h000001);
      check("set1_diff", 64'(led2_aled2_val), 64'(DIFF0[47:24]));
      check("set1_idle", {busy, overrun}, 64'h0);

      // Reads gated by ini_over
      ini_over = 1'b0;
      seen = 1'b0;
      fork
         begin
            pulse_adc();
            repeat (4) @(negedge div_clk);
            pulse_adc();
         end
         begin
            for (int i = 0; i < 30; i++) begin
               @(negedge div_clk);
               if (rd_wr_en || busy) seen = 1'b1;
            end
         end
      join
      check("gated_activity", 64'(seen), 64'd0);
      check("gated_no_set", 64'(n_valid), 64'd1);

      // Overrun during DATA_M of 0x2B; ini_over dropped mid-set
      ini_over = 1'b1;
      resp_var = 1;
      exp_q.push_back(EXP1);
      pulse_adc();
      wait_state(3'd3, 1, "reach_2b_data_m");
      pulse_adc();
      ini_over = 1'b0;
      wait_valid(2, "set2_valid");
      repeat (40) @(negedge div_clk);
      check("overrun_set", 64'(overrun), 64'd1);
      check("no_extra_set", 64'(n_valid), 64'd2);
      check("set2_idle", 64'(busy), 64'd0);
      overrun_clr = 1'b1;
      @(negedge div_clk);
      overrun_clr = 1'b0;
      check("overrun_clr", 64'(overrun), 64'd0);

      // Reset during DATA_H of 0x2C
      ini_over = 1'b1;
      resp_var = 0;
      pulse_adc();
      wait_state(3'd2, 2, "reach_2c_data_h");
      rst_n = 1'b0;
      #1;
      check("mid_rst_ctrl", {rd_wr_en, rd_rd_en, rd_tx_data, data_part, data_valid, busy, overrun}, 64'h0);
      check("mid_rst_led2_aled2", {led2_val, aled2_val}, 64'h0);
      check("mid_rst_led1_aled1", {led1_val, aled1_val}, 64'h0);
      check("mid_rst_diff", {led2_aled2_val, led1_aled1_val}, 64'h0);
      repeat (8) @(negedge div_clk);
      rst_n = 1'b1;
      dv0 = n_valid;
      repeat (30) @(negedge div_clk);
      check("abandoned_set", 64'(n_valid - dv0), 64'd0);

      // Restart after reset begins at 0x2A
      spi0 = n_spi;
      exp_q.push_back(EXP0);
      pulse_adc();
      wait_valid(dv0 + 1, "set3_valid");
      repeat (5) @(negedge div_clk);
      check("restart_addr", 64'(first_tx), 64'h2A);
      check("set3_spi_count", 64'(n_spi - spi0), 64'(SPI_PER_SET));
      n = exp_q.size();
      check("queue_drained", 64'(n), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
